seq_detector_param: RTL and testbench

- Parametrised serial sequence detector for the single-bit input stream w. Moore-style, like the existing fixed 8-state detector.
- Runs two detectors in parallel:
  - Run detector: RUN_LEN consecutive ones.
  - Pattern detector: PAT_W-bit pattern, programmable at runtime.
- Adds sample enable, overlap/non-overlap mode, a saturating match counter and a combined flag z.
- Sits at the serial-input front end of lab datapaths. Drives LED/status logic.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_hist.sv | 61 ++++++
 rtl/seq_detector_param.sv | 100 ++++++++++
 tb/tb_seq_detector_param.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and width helper for the parametrised serial sequence detector.
package seq_det_pkg;

  localparam int DEF_RUN_LEN = 4;
  localparam int DEF_PAT_W   = 4;
  localparam int DEF_CNT_W   = 8;
  localparam logic [DEF_PAT_W-1:0] DEF_PAT_INIT = 4'b1001;

  // Bits needed to hold every value 0..max_val, never fewer than one.
  function automatic int clog2_sat(input int max_val);
    int bits;
    bits = 1;
    while ((1 << bits) <= max_val) bits = bits + 1;
    return bits;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Pattern path: history shift register, fill counter, compare and hit/overlap clearing.
module seq_det_hist
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_i,
  input  logic             clear_i,
  input  logic             overlap_i,
  input  logic             w_i,
  input  logic [PAT_W-1:0] pat_i,
  output logic             hit_o,
  output logic             pat_hit_o
);

  localparam int FW = clog2_sat(PAT_W);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d, nhist;
  logic [FW-1:0]    fill_q, fill_d, nfill;
  logic             pat_hit_q, pat_hit_d;
  logic             hit;

  // fill counts valid history bits so pre-stream zeros can never match.
  assign nhist = {hist_q[PAT_W-2:0], w_i};
  assign nfill = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
  assign hit   = (nfill == FILL_FULL) && (nhist == pat_i);

  always_comb begin
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_hit_d = pat_hit_q;
    if (clear_i) begin
      hist_d    = '0;
      fill_d    = '0;
      pat_hit_d = 1'b0;
    end else if (sample_i) begin
      hist_d    = nhist;
      fill_d    = (hit && !overlap_i) ? '0 : nfill;
      pat_hit_d = hit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pat_hit_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_hit_q <= pat_hit_d;
    end
  end

  assign hit_o     = sample_i && !clear_i && hit;
  assign pat_hit_o = pat_hit_q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial detector: run-of-ones and programmable-pattern detectors in parallel,
// with a saturating pattern-match counter. All outputs decode registered state.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               RUN_LEN  = DEF_RUN_LEN,
  parameter int               PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(DEF_PAT_INIT),
  parameter int               CNT_W    = DEF_CNT_W
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             en,
  input  logic             w,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             z_run,
  output logic             z_pat,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int RW = clog2_sat(RUN_LEN);
  localparam logic [RW-1:0]    RUN_MAX = RW'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [RW-1:0]    run_cnt_q, run_cnt_d;
  logic [PAT_W-1:0] pat_reg_q, pat_reg_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             cnt_sat_q, cnt_sat_d;
  logic             sample, hit, pat_hit;

  // A pattern load swallows the concurrent sample for both detectors.
  assign sample = en && !pat_load;

  seq_det_hist #(.PAT_W(PAT_W)) u_hist (
    .clk_i     (Clock),
    .rst_ni    (Resetn),
    .sample_i  (sample),
    .clear_i   (pat_load),
    .overlap_i (overlap),
    .w_i       (w),
    .pat_i     (pat_reg_q),
    .hit_o     (hit),
    .pat_hit_o (pat_hit)
  );

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (sample) begin
      if (!w)                        run_cnt_d = '0;
      else if (run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + RW'(1);
    end
  end

  always_comb begin
    pat_reg_d = pat_load ? pat_in : pat_reg_q;
  end

  // cnt_clr beats a simultaneous hit; the counter holds once at its maximum.
  always_comb begin
    match_cnt_d = match_cnt_q;
    cnt_sat_d   = cnt_sat_q;
    if (cnt_clr) begin
      match_cnt_d = '0;
      cnt_sat_d   = 1'b0;
    end else if (hit) begin
      if (match_cnt_q != CNT_MAX) begin
        match_cnt_d = match_cnt_q + CNT_W'(1);
        cnt_sat_d   = (match_cnt_q == CNT_MAX - CNT_W'(1));
      end else begin
        cnt_sat_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      run_cnt_q   <= '0;
      pat_reg_q   <= PAT_INIT;
      match_cnt_q <= '0;
      cnt_sat_q   <= 1'b0;
    end else begin
      run_cnt_q   <= run_cnt_d;
      pat_reg_q   <= pat_reg_d;
      match_cnt_q <= match_cnt_d;
      cnt_sat_q   <= cnt_sat_d;
    end
  end

  assign z_run     = (run_cnt_q == RUN_MAX);
  assign z_pat     = pat_hit;
  assign z         = z_run | z_pat;
  assign match_cnt = match_cnt_q;
  assign cnt_sat   = cnt_sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default instance plus a 2-bit-counter instance.
module tb_seq_detector_param;

  logic       Clock = 1'b0;
  logic       Resetn, en, w, overlap, pat_load, cnt_clr;
  logic [3:0] pat_in;
  logic       z_run, z_pat, z, cnt_sat;
  logic [7:0] match_cnt;
  logic       z_run_s, z_pat_s, z_s, cnt_sat_s;
  logic [1:0] match_cnt_s;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 Clock = ~Clock;

  seq_detector_param dut (
    .Clock(Clock), .Resetn(Resetn), .en(en), .w(w), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z_run(z_run), .z_pat(z_pat), .z(z), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.CNT_W(2)) dut_sat (
    .Clock(Clock), .Resetn(Resetn), .en(en), .w(w), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z_run(z_run_s), .z_pat(z_pat_s), .z(z_s), .match_cnt(match_cnt_s), .cnt_sat(cnt_sat_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic feed(input logic wv);
    en = 1'b1;
    w  = wv;
    tick();
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    en     = 1'b0;
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  initial begin
    logic [5:0]  run_w, run_exp;
    logic [6:0]  ov_w, ov_exp_on, ov_exp_off;
    logic [12:0] sat_w, sat_exp;

    Resetn = 1'b0; en = 1'b0; w = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;

    // Reset, idle, then default pattern 1001
    do_reset();
    tick();
    tick();
    check("rst_z", z, 0);
    check("rst_z_run", z_run, 0);
    check("rst_z_pat", z_pat, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_sat", cnt_sat, 0);
    feed(1); feed(0); feed(0);
    check("init_pat_e3", z_pat, 0);
    feed(1);
    check("init_pat_e4", z_pat, 1);
    check("init_z_e4", z, 1);
    check("init_cnt", match_cnt, 1);

    // Run of ones
    do_reset();
    run_w   = 6'b111110;
    run_exp = 6'b000110;
    for (int i = 5; i >= 0; i--) begin
      feed(run_w[i]);
      check($sformatf("run_z_run_e%0d", 6 - i), z_run, run_exp[i]);
      check($sformatf("run_z_e%0d", 6 - i), z, run_exp[i]);
    end
    check("run_cnt", match_cnt, 0);

    // Overlap on / off
    ov_w       = 7'b1001001;
    ov_exp_on  = 7'b0001001;
    ov_exp_off = 7'b0001000;
    do_reset();
    overlap = 1'b1;
    for (int i = 6; i >= 0; i--) begin
      feed(ov_w[i]);
      check($sformatf("ovl_on_e%0d", 7 - i), z_pat, ov_exp_on[i]);
    end
    check("ovl_on_cnt", match_cnt, 2);
    do_reset();
    overlap = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      feed(ov_w[i]);
      check($sformatf("ovl_off_e%0d", 7 - i), z_pat, ov_exp_off[i]);
    end
    check("ovl_off_cnt", match_cnt, 1);

    // Enable gating and runtime pattern load
    do_reset();
    overlap = 1'b1;
    feed(1); feed(0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = i[0];
      tick();
      check($sformatf("hold_lo_pat_%0d", i), z_pat, 0);
      check($sformatf("hold_lo_run_%0d", i), z_run, 0);
    end
    feed(0);
    check("gate_e3", z_pat, 0);
    feed(1);
    check("gate_e4", z_pat, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = ~i[0];
      tick();
      check($sformatf("hold_hi_pat_%0d", i), z_pat, 1);
    end
    // run_cnt is 1 here; two more ones bring it to 3
    feed(1); feed(1);
    check("pre_load_run", z_run, 0);
    pat_in   = 4'b0110;
    pat_load = 1'b1;
    feed(1);
    pat_load = 1'b0;
    check("load_drop_run", z_run, 0);
    check("load_clr_pat", z_pat, 0);
    feed(0); feed(1); feed(1);
    check("load_pat_e3", z_pat, 0);
    feed(0);
    check("load_pat_e4", z_pat, 1);
    check("load_cnt", match_cnt, 2);

    // Counter saturation on the 2-bit instance
    do_reset();
    overlap = 1'b1;
    sat_w   = 13'b1001001001001;
    sat_exp = 13'b0001001001001;
    for (int i = 12; i >= 0; i--) begin
      feed(sat_w[i]);
      check($sformatf("sat_pat_e%0d", 13 - i), z_pat_s, sat_exp[i]);
      if (i == 6) begin
        check("sat_cnt_2", match_cnt_s, 2);
        check("sat_flag_2", cnt_sat_s, 0);
      end
      if (i == 3) begin
        check("sat_cnt_3", match_cnt_s, 3);
        check("sat_flag_3", cnt_sat_s, 1);
      end
    end
    check("sat_cnt_4", match_cnt_s, 3);
    check("sat_flag_4", cnt_sat_s, 1);
    check("sat_wide_cnt_4", match_cnt, 4);
    feed(0); feed(0);
    cnt_clr = 1'b1;
    feed(1);
    cnt_clr = 1'b0;
    check("clr_hit_pat", z_pat_s, 1);
    check("clr_cnt", match_cnt_s, 0);
    check("clr_flag", cnt_sat_s, 0);
    check("clr_wide_cnt", match_cnt, 0);

    // Reset in the middle of a run
    do_reset();
    feed(1); feed(1); feed(1);
    Resetn = 1'b0;
    en = 1'b1; w = 1'b1;
    tick();
    Resetn = 1'b1;
    check("midrst_run", z_run, 0);
    check("midrst_z", z, 0);
    for (int i = 1; i <= 4; i++) begin
      feed(1);
      check($sformatf("midrst_run_e%0d", i), z_run, (i == 4) ? 1 : 0);
    end

    en = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
